align_batch_sched: RTL
======================

# align_batch_sched

Batch scheduler in front of the MAC alignment stage. It collects a fixed-size batch of partial products, each a 4-bit sign/denormalized mantissa and a 6-bit exponent. While collecting, it tracks the batch maximum exponent. It then issues the stored entries to the aligner one per cycle, with the common `max_exp`, the batch `Q_frac` and a lane index. The aligner has no backpressure, so this block owns all sequencing: accept, hold, issue, flush.

## Interface
Parameters:
- `N`, default 9: entries per batch, legal range 2..16.
- `LW`, default 4: lane index width, must satisfy 2^LW ≥ N.

Ports:
- `i_clk`, in, 1: clock. Single clock domain.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: input entry present.
- `o_ready`, out, 1: block accepts input this cycle.
- `i_denorm_pp`, in, 4: [3] sign, [2:0] leading-one mantissa.
- `i_exp`, in, 6: unsigned exponent of the entry.
- `i_Q_frac`, in, 5: fraction format tag. Sampled on the first accepted entry of a batch.
- `i_flush`, in, 1: synchronous abort of the current batch.
- `o_valid`, out, 1: issue beat to the aligner.
- `o_denorm_pp`, out, 4: stored entry.
- `o_exp`, out, 6: stored exponent.
- `o_max_exp`, out, 6: batch maximum exponent, constant across the batch.
- `o_Q_frac`, out, 5: batch tag.
- `o_lane`, out, `LW`: entry index 0..N-1.
- `o_last`, out, 1: high with lane N-1.
- `o_busy`, out, 1: state ≠ COLLECT, or count ≠ 0.

## Operation
- Storage: N-entry register file of {pp[3:0], exp[5:0]}. Running max register `mx` (6 b), count `cnt`, issue pointer `ptr`.
- State COLLECT:
  - `o_ready`=1.
  - Accept = `i_valid & o_ready`.
  - On accept, write entry[cnt] and increment `cnt`.
  - `mx` is loaded with `i_exp` when `cnt`=0. Otherwise `mx` = max(`mx`, `i_exp`), unsigned compare.
  - `i_Q_frac` is latched when `cnt`=0.
  - On the accept where `cnt`=N-1: go to ISSUE, clear `cnt`, set `ptr`=0.
- State ISSUE:
  - `o_ready`=0.
  - Every cycle: `o_valid`=1 with entry[ptr], `o_lane`=ptr, `o_max_exp`=`mx`. Then `ptr` increments.
  - `o_last`=1 when ptr=N-1; the next state is COLLECT.
  - Issue beats are never stalled.
- Invariant: `o_exp` ≤ `o_max_exp` on every valid beat, so the aligner's exponent difference never borrows.
- Flush:
  - `i_flush`=1 in any state: next cycle is COLLECT, with `cnt`=0 and `ptr`=0. `o_valid`, `o_last` and `mx` go to 0.
  - Flush and accept in the same cycle: flush wins and the entry is dropped.
  - Flush in the last COLLECT slot: the batch is dropped and nothing is issued.
- Outputs:
  - All issue outputs are registered.
  - When `o_valid`=0, the data outputs hold 0.
  - `o_ready` is decoded from the state register only; there is no combinational path from `i_valid`.

## Timing
- Reset, asynchronous and immediate:
  - State = COLLECT; `cnt`, `ptr`, `mx` = 0.
  - `o_valid`, `o_last`, `o_busy`, `o_lane`, `o_denorm_pp`, `o_exp`, `o_max_exp`, `o_Q_frac` = 0.
  - `o_ready`=1 once `i_rst_n` deasserts.
  - Storage contents are don't-care.
- Latency: the Nth accept occurs at edge T. The first issue beat is visible after edge T+1 and the last after edge T+N. The first new accept is possible in the cycle after `o_last`.
- Throughput: one batch per 2N cycles with a gapless input stream.
- Reset asserted mid-ISSUE: `o_valid` drops at once; no partial batch resumes.
- N=2 boundary: the FSM must still produce exactly 2 beats, lanes 0 and 1.

## Configuration
- `ALIGN_SCHED_ZERO_SKIP_EN`:
  - Defined: entries with `i_denorm_pp[2:0]`=0 are stored and issued normally, but are excluded from the `mx` computation. If every entry in a batch is zero, `o_max_exp`=0.
    - Because such an entry may have `o_exp` > `o_max_exp`, the issue stage forces `o_exp`=`o_max_exp` for it. The aligner then sees exponent difference 0 and a zero mantissa.
  - Undefined: every entry updates `mx` as described under Operation, and `o_exp` is the stored value.

## Test plan
- Reset then N=9 entries, exps 3,7,1,12,0,5,12,2,9, pp=4'h5 each, `i_Q_frac`=5'h0A on entry 0 → 9 beats, lanes 0..8, `o_max_exp`=12, `o_Q_frac`=0x0A, `o_last` on lane 8, `o_ready`=0 for exactly 9 cycles.
- Back-to-back batches, `i_valid` held high → no accept during ISSUE; second batch `mx` is recomputed from its own first entry, e.g. exps all 2 → `o_max_exp`=2.
- `i_flush` with accept of entry 4 → entry dropped; the following 9 accepts form a full batch; first issued lane 0 is the post-flush entry.
- `i_flush` on ISSUE beat lane 3 → `o_valid`=0 next cycle, `o_busy`=0, `o_ready`=1.
- `i_rst_n` pulsed low mid-ISSUE → all outputs 0 immediately; after release, a fresh batch issues correctly.
- With `ALIGN_SCHED_ZERO_SKIP_EN`: entry 0 = {pp=4'h8, exp=63}, remaining exps ≤ 10 → `o_max_exp`=10; lane 0 beat shows `o_exp`=10. Without the macro, the same stimulus gives `o_max_exp`=63.

Source files
------------

// File: rtl/align_batch_sched.sv
// Batch scheduler ahead of the MAC aligner: collects N partial products, tracks the max exponent,
// then issues them one per cycle. Optional ALIGN_SCHED_ZERO_SKIP_EN excludes zero mantissas from max.
module align_batch_sched #(
    parameter int N  = 9,
    parameter int LW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [3:0]    i_denorm_pp,
    input  logic [5:0]    i_exp,
    input  logic [4:0]    i_Q_frac,
    input  logic          i_flush,
    output logic          o_valid,
    output logic [3:0]    o_denorm_pp,
    output logic [5:0]    o_exp,
    output logic [5:0]    o_max_exp,
    output logic [4:0]    o_Q_frac,
    output logic [LW-1:0] o_lane,
    output logic          o_last,
    output logic          o_busy
);
    localparam logic [0:0]    S_COLLECT = 1'b0;
    localparam logic [0:0]    S_ISSUE   = 1'b1;
    localparam logic [LW-1:0] LAST      = LW'(N - 1);

    logic [0:0]          r_state;
    logic [LW-1:0]       r_cnt;
    logic [LW-1:0]       r_ptr;
    logic [5:0]          r_mx;
    logic [4:0]          r_qf;
    logic [N-1:0][3:0]   r_pp;
    logic [N-1:0][5:0]   r_ex;

    logic                w_accept;
    logic                w_in_skip;
    logic [5:0]          w_in_exp;
    logic [5:0]          w_mx_nxt;
    logic [3:0]          w_iss_pp;
    logic [5:0]          w_iss_exp;

    assign o_ready  = (r_state == S_COLLECT);
    assign o_busy   = (r_state != S_COLLECT) || (r_cnt != '0);
    assign w_accept = i_valid & o_ready;
    assign w_iss_pp = r_pp[r_ptr];

`ifdef ALIGN_SCHED_ZERO_SKIP_EN
    // Zero mantissas don't vote on the max; clamp their exponent so the aligner's diff stays >= 0.
    assign w_in_skip = (i_denorm_pp[2:0] == 3'd0);
    assign w_iss_exp = (w_iss_pp[2:0] == 3'd0) ? r_mx : r_ex[r_ptr];
`else
    assign w_in_skip = 1'b0;
    assign w_iss_exp = r_ex[r_ptr];
`endif

    assign w_in_exp = w_in_skip ? 6'd0 : i_exp;
    assign w_mx_nxt = (r_cnt == '0)       ? w_in_exp :
                      (w_in_exp > r_mx)   ? w_in_exp : r_mx;

    // Entry storage needs no reset; it is always written before it is read.
    always_ff @(posedge i_clk) begin
        if (w_accept && !i_flush) begin
            r_pp[r_cnt] <= i_denorm_pp;
            r_ex[r_cnt] <= i_exp;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_COLLECT;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_mx        <= '0;
            r_qf        <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_lane      <= '0;
            o_denorm_pp <= '0;
            o_exp       <= '0;
            o_max_exp   <= '0;
            o_Q_frac    <= '0;
        end else if (i_flush) begin
            r_state     <= S_COLLECT;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_mx        <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_lane      <= '0;
            o_denorm_pp <= '0;
            o_exp       <= '0;
            o_max_exp   <= '0;
            o_Q_frac    <= '0;
        end else if (r_state == S_COLLECT) begin
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_lane      <= '0;
            o_denorm_pp <= '0;
            o_exp       <= '0;
            o_max_exp   <= '0;
            o_Q_frac    <= '0;
            if (w_accept) begin
                r_mx <= w_mx_nxt;
                if (r_cnt == '0) r_qf <= i_Q_frac;
                if (r_cnt == LAST) begin
                    r_state <= S_ISSUE;
                    r_cnt   <= '0;
                    r_ptr   <= '0;
                end else begin
                    r_cnt <= r_cnt + LW'(1);
                end
            end
        end else begin
            o_valid     <= 1'b1;
            o_last      <= (r_ptr == LAST);
            o_lane      <= r_ptr;
            o_denorm_pp <= w_iss_pp;
            o_exp       <= w_iss_exp;
            o_max_exp   <= r_mx;
            o_Q_frac    <= r_qf;
            if (r_ptr == LAST) begin
                r_state <= S_COLLECT;
                r_ptr   <= '0;
            end else begin
                r_ptr <= r_ptr + LW'(1);
            end
        end
    end
endmodule
